// File: rtl/tile_pass_sequencer_if.sv
// Layer configuration, pass handshake and per-pass GLB addressing shared by the
// layer controller, tile_pass_sequencer and token_engine.
interface tile_pass_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              layer_start_i;
    logic [15:0]       IC_i;
    logic [15:0]       OC_i;
    logic [7:0]        num_n_tiles_i;
    logic              bias_en_i;
    logic [ADDR_W-1:0] weight_base_i;
    logic [ADDR_W-1:0] ifmap_base_i;
    logic [ADDR_W-1:0] opsum_base_i;
    logic [ADDR_W-1:0] bias_base_i;
    logic [ADDR_W-1:0] w_tile_stride_i;
    logic [ADDR_W-1:0] ifmap_n_stride_i;
    logic [ADDR_W-1:0] ifmap_ic_stride_i;
    logic [ADDR_W-1:0] opsum_n_stride_i;
    logic [ADDR_W-1:0] opsum_oc_stride_i;
    logic              pass_done_i;
    logic              pass_start_o;
    logic [ADDR_W-1:0] weight_GLB_base_addr_o;
    logic [ADDR_W-1:0] ifmap_GLB_base_addr_o;
    logic [ADDR_W-1:0] ipsum_GLB_base_addr_o;
    logic [ADDR_W-1:0] opsum_GLB_base_addr_o;
    logic [ADDR_W-1:0] bias_GLB_base_addr_o;
    logic              is_bias_o;
    logic              ipsum_zero_o;
    logic [31:0]       tile_n_o;
    logic [7:0]        IC_real_o;
    logic [7:0]        OC_real_o;
    logic              busy_o;
    logic              layer_done_o;

    modport master (
        output layer_start_i, IC_i, OC_i, num_n_tiles_i, bias_en_i,
               weight_base_i, ifmap_base_i, opsum_base_i, bias_base_i,
               w_tile_stride_i, ifmap_n_stride_i, ifmap_ic_stride_i,
               opsum_n_stride_i, opsum_oc_stride_i, pass_done_i,
        input  pass_start_o, weight_GLB_base_addr_o, ifmap_GLB_base_addr_o,
               ipsum_GLB_base_addr_o, opsum_GLB_base_addr_o, bias_GLB_base_addr_o,
               is_bias_o, ipsum_zero_o, tile_n_o, IC_real_o, OC_real_o,
               busy_o, layer_done_o
    );

    modport slave (
        input  layer_start_i, IC_i, OC_i, num_n_tiles_i, bias_en_i,
               weight_base_i, ifmap_base_i, opsum_base_i, bias_base_i,
               w_tile_stride_i, ifmap_n_stride_i, ifmap_ic_stride_i,
               opsum_n_stride_i, opsum_oc_stride_i, pass_done_i,
        output pass_start_o, weight_GLB_base_addr_o, ifmap_GLB_base_addr_o,
               ipsum_GLB_base_addr_o, opsum_GLB_base_addr_o, bias_GLB_base_addr_o,
               is_bias_o, ipsum_zero_o, tile_n_o, IC_real_o, OC_real_o,
               busy_o, layer_done_o
    );
endinterface

// File: rtl/tile_pass_sequencer.sv
// Walks one layer as token_engine passes (n outer, OC middle, IC inner), issuing
// stable per-pass GLB addresses and channel counts for each pass.
module tile_pass_sequencer #(
    parameter int IC_MAX = 32,
    parameter int OC_MAX = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    tile_pass_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, ADVANCE, DONE} state_t;

    state_t            state;
    logic [15:0]       ic_r, oc_r, n_ic, n_oc, ic_t, oc_t;
    logic [7:0]        num_n_r, n_t;
    logic              bias_en_r, last_pass;
    logic [ADDR_W-1:0] weight_base_r, ifmap_base_r, opsum_base_r, bias_base_r;
    logic [ADDR_W-1:0] w_tile_stride_r, ifmap_n_stride_r, ifmap_ic_stride_r;
    logic [ADDR_W-1:0] opsum_n_stride_r, opsum_oc_stride_r;

    logic [ADDR_W-1:0] weight_c, ifmap_c, opsum_c, bias_c;
    logic              is_bias_c, ipsum_zero_c, empty_layer, load_pass;
    logic [7:0]        ic_real_c, oc_real_c;

    function automatic logic [15:0] ceil_tiles(input logic [15:0] total, input int unsigned tile);
        return 16'((32'(total) + tile - 32'd1) / tile);
    endfunction

    // Channels left in this tile, saturated to the array dimension.
    function automatic logic [7:0] sat_real(input logic [15:0] total, input logic [15:0] idx,
                                            input int unsigned tile);
        logic [31:0] rem;
        rem = 32'(total) - 32'(idx) * tile;
        return (rem > tile) ? 8'(tile) : 8'(rem);
    endfunction

    assign empty_layer = (ic_r == 16'd0) || (oc_r == 16'd0) || (num_n_r == 8'd0);
    assign load_pass   = ((state == SETUP) && !empty_layer) || ((state == ADVANCE) && !last_pass);

    always_comb begin
        weight_c     = weight_base_r
                     + (ADDR_W'(oc_t) * ADDR_W'(n_ic) + ADDR_W'(ic_t)) * w_tile_stride_r;
        ifmap_c      = ifmap_base_r + ADDR_W'(n_t) * ifmap_n_stride_r
                     + ADDR_W'(ic_t) * ifmap_ic_stride_r;
        opsum_c      = opsum_base_r + ADDR_W'(n_t) * opsum_n_stride_r
                     + ADDR_W'(oc_t) * opsum_oc_stride_r;
        bias_c       = bias_base_r + ADDR_W'(oc_t) * ADDR_W'(OC_MAX * 4);
        is_bias_c    = (ic_t == 16'd0) && bias_en_r;
        ipsum_zero_c = (ic_t == 16'd0) && !bias_en_r;
        ic_real_c    = sat_real(ic_r, ic_t, IC_MAX);
        oc_real_c    = sat_real(oc_r, oc_t, OC_MAX);
    end

    // Per-pass outputs are captured as the FSM enters ISSUE and hold through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.weight_GLB_base_addr_o <= '0;
            bus.ifmap_GLB_base_addr_o  <= '0;
            bus.ipsum_GLB_base_addr_o  <= '0;
            bus.opsum_GLB_base_addr_o  <= '0;
            bus.bias_GLB_base_addr_o   <= '0;
            bus.is_bias_o              <= 1'b0;
            bus.ipsum_zero_o           <= 1'b0;
            bus.tile_n_o               <= '0;
            bus.IC_real_o              <= '0;
            bus.OC_real_o              <= '0;
        end else if (load_pass) begin
            bus.weight_GLB_base_addr_o <= weight_c;
            bus.ifmap_GLB_base_addr_o  <= ifmap_c;
            bus.ipsum_GLB_base_addr_o  <= is_bias_c ? bias_c : opsum_c;
            bus.opsum_GLB_base_addr_o  <= opsum_c;
            bus.bias_GLB_base_addr_o   <= bias_c;
            bus.is_bias_o              <= is_bias_c;
            bus.ipsum_zero_o           <= ipsum_zero_c;
            bus.tile_n_o               <= 32'(n_t);
            bus.IC_real_o              <= ic_real_c;
            bus.OC_real_o              <= oc_real_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            bus.pass_start_o  <= 1'b0;
            bus.layer_done_o  <= 1'b0;
            bus.busy_o        <= 1'b0;
            ic_r              <= '0;
            oc_r              <= '0;
            num_n_r           <= '0;
            bias_en_r         <= 1'b0;
            n_ic              <= '0;
            n_oc              <= '0;
            ic_t              <= '0;
            oc_t              <= '0;
            n_t               <= '0;
            last_pass         <= 1'b0;
            weight_base_r     <= '0;
            ifmap_base_r      <= '0;
            opsum_base_r      <= '0;
            bias_base_r       <= '0;
            w_tile_stride_r   <= '0;
            ifmap_n_stride_r  <= '0;
            ifmap_ic_stride_r <= '0;
            opsum_n_stride_r  <= '0;
            opsum_oc_stride_r <= '0;
        end else begin
            bus.pass_start_o <= 1'b0;
            bus.layer_done_o <= 1'b0;
            case (state)
                IDLE: if (bus.layer_start_i) begin
                    ic_r              <= bus.IC_i;
                    oc_r              <= bus.OC_i;
                    num_n_r           <= bus.num_n_tiles_i;
                    bias_en_r         <= bus.bias_en_i;
                    n_ic              <= ceil_tiles(bus.IC_i, IC_MAX);
                    n_oc              <= ceil_tiles(bus.OC_i, OC_MAX);
                    weight_base_r     <= bus.weight_base_i;
                    ifmap_base_r      <= bus.ifmap_base_i;
                    opsum_base_r      <= bus.opsum_base_i;
                    bias_base_r       <= bus.bias_base_i;
                    w_tile_stride_r   <= bus.w_tile_stride_i;
                    ifmap_n_stride_r  <= bus.ifmap_n_stride_i;
                    ifmap_ic_stride_r <= bus.ifmap_ic_stride_i;
                    opsum_n_stride_r  <= bus.opsum_n_stride_i;
                    opsum_oc_stride_r <= bus.opsum_oc_stride_i;
                    ic_t              <= '0;
                    oc_t              <= '0;
                    n_t               <= '0;
                    last_pass         <= 1'b0;
                    bus.busy_o        <= 1'b1;
                    state             <= SETUP;
                end
                SETUP: begin
                    if (empty_layer) begin
                        bus.layer_done_o <= 1'b1;
                        state            <= DONE;
                    end else begin
                        bus.pass_start_o <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: if (bus.pass_done_i) begin
                    last_pass <= (ic_t == n_ic - 16'd1) && (oc_t == n_oc - 16'd1)
                               && (n_t == num_n_r - 8'd1);
                    if (ic_t == n_ic - 16'd1) begin
                        ic_t <= '0;
                        if (oc_t == n_oc - 16'd1) begin
                            oc_t <= '0;
                            n_t  <= (n_t == num_n_r - 8'd1) ? 8'd0 : n_t + 8'd1;
                        end else begin
                            oc_t <= oc_t + 16'd1;
                        end
                    end else begin
                        ic_t <= ic_t + 16'd1;
                    end
                    state <= ADVANCE;
                end
                ADVANCE: begin
                    if (last_pass) begin
                        bus.layer_done_o <= 1'b1;
                        state            <= DONE;
                    end else begin
                        bus.pass_start_o <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                DONE: begin
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tile_pass_sequencer.md
Name: tile_pass_sequencer

Overview:
- Sits directly upstream of token_engine and drives one layer as a sequence of token_engine passes, one pass per (n-tile, OC-tile, IC-tile).
- Latches the layer configuration on start and walks the tile loops, ordered n outer, OC middle, IC inner.
- For each pass it presents stable GLB base addresses, real channel counts and bias/ipsum selection, pulses pass_start_o, and waits for pass_done_i.

Parameters:
IC_MAX, 32, IC channels per tile (PE array rows)
OC_MAX, 32, OC channels per tile (PE array columns)
ADDR_W, 32, GLB address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
layer_start_i  in  1  start layer; accepted only in IDLE
IC_i  in  16  total input channels
OC_i  in  16  total output channels
num_n_tiles_i  in  8  spatial tiles in the layer
bias_en_i  in  1  first IC tile loads bias; else ipsum starts at zero
weight_base_i  in  ADDR_W  weight GLB base
ifmap_base_i  in  ADDR_W  ifmap GLB base
opsum_base_i  in  ADDR_W  opsum GLB base
bias_base_i  in  ADDR_W  bias GLB base
w_tile_stride_i  in  ADDR_W  bytes per weight tile
ifmap_n_stride_i  in  ADDR_W  ifmap bytes per n-tile
ifmap_ic_stride_i  in  ADDR_W  ifmap bytes per IC tile
opsum_n_stride_i  in  ADDR_W  opsum bytes per n-tile
opsum_oc_stride_i  in  ADDR_W  opsum bytes per OC tile
pass_done_i  in  1  pass complete pulse from token_engine
pass_start_o  out  1  one-cycle pass start to token_engine
weight_GLB_base_addr_o  out  ADDR_W  per-pass weight address
ifmap_GLB_base_addr_o  out  ADDR_W  per-pass ifmap address
ipsum_GLB_base_addr_o  out  ADDR_W  per-pass ipsum address
opsum_GLB_base_addr_o  out  ADDR_W  per-pass opsum address
bias_GLB_base_addr_o  out  ADDR_W  per-pass bias address
is_bias_o  out  1  this pass reads bias as ipsum
ipsum_zero_o  out  1  this pass starts from zero psum
tile_n_o  out  32  current n-tile index
IC_real_o  out  8  valid IC in this tile
OC_real_o  out  8  valid OC in this tile
busy_o  out  1  high outside IDLE
layer_done_o  out  1  one-cycle layer completion pulse

Behaviour:
- Reset: state=IDLE; all outputs and counters 0. A reset asserted in any state (including WAIT) aborts the layer; no layer_done_o is emitted.
- IDLE: on layer_start_i, latch all cfg inputs and go to SETUP. Cfg input changes after acceptance have no effect.
- SETUP (1 cycle):
  - n_ic = ceil(IC/IC_MAX); n_oc = ceil(OC/OC_MAX); counters n_t = oc_t = ic_t = 0.
  - If IC=0, OC=0 or num_n_tiles=0, go to DONE; otherwise go to ISSUE.
- ISSUE (1 cycle): pass_start_o=1, then go to WAIT.
- All per-pass outputs are registered and valid from the ISSUE cycle through the end of WAIT:
  - weight = weight_base + (oc_t*n_ic + ic_t)*w_tile_stride
  - ifmap = ifmap_base + n_t*ifmap_n_stride + ic_t*ifmap_ic_stride
  - opsum = opsum_base + n_t*opsum_n_stride + oc_t*opsum_oc_stride
  - bias = bias_base + oc_t*OC_MAX*4
  - ipsum = bias if is_bias, else opsum (in-place accumulate)
  - is_bias = (ic_t==0) & bias_en; ipsum_zero = (ic_t==0) & !bias_en
  - IC_real = min(IC_MAX, IC - ic_t*IC_MAX); OC_real likewise
  - tile_n_o = n_t
  - Arithmetic is unsigned, truncated to ADDR_W.
- WAIT: on pass_done_i, go to ADVANCE. pass_done_i in any other state is ignored.
- ADVANCE (1 cycle):
  - ic_t++. On wrap at n_ic: ic_t=0, oc_t++. On wrap at n_oc: oc_t=0, n_t++.
  - If n_t wraps at num_n_tiles, go to DONE; else go to ISSUE.
  - Per-pass outputs update in this cycle.
- DONE (1 cycle): layer_done_o=1, then go to IDLE.
- Latency:
  - layer_start_i at cycle t gives pass_start_o at t+2.
  - pass_done_i at cycle t gives the next pass_start_o at t+2.
  - pass_done_i on the last pass at cycle t gives layer_done_o at t+2.
- layer_start_i while busy_o=1 is ignored.
- If pass_done_i coincides with pass_start_o, it is ignored (state is ISSUE).

Test Plan:
- IC=32, OC=32, n=1, bias_en=1, layer_start at cycle 0 -> pass_start at 2, is_bias=1, IC_real=OC_real=32; pass_done at 10 -> layer_done at 12.
- IC=70, OC=40, n=2, w_stride=0x400 -> exactly 12 passes, order (n,oc,ic) = (0,0,0),(0,0,1),(0,0,2),(0,1,0)...; IC_real sequence 32,32,6; OC_real 32 then 8; pass 5 (0,1,1) has weight addr base+0x1000.
- bias_en=0, IC=64 -> ic_t=0 passes: ipsum_zero=1, is_bias=0; ic_t=1 passes: ipsum addr equals opsum addr.
- IC=0 -> no pass_start; layer_done at cycle 2; busy high for cycles 1-2 only.
- pass_done pulses during IDLE and ISSUE, plus layer_start during WAIT -> no state change; pass count unchanged.
- rst asserted in WAIT of pass 3 -> next cycle all outputs 0, IDLE, no layer_done; new layer_start restarts at tile (0,0,0).
